data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the core's load/store path (port 0) and a trigger-driven loader/debug requester (port 1). It sits between both requesters and the data memory, converting per-port valid/ready requests into one memory access per cycle. It uses round-robin priority, optional locked bursts with a watchdog timeout, and registered read responses.

---
 rtl/data_mem_arbiter_if.sv | 36 +++
 rtl/data_mem_arbiter.sv | 78 +++++++
 tb/tb_data_mem_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: both requester ports and the data memory side of the arbiter
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
);
  logic                  req0_valid, req0_we, req0_lock, req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  req1_valid, req1_we, req1_lock, req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );
  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port data memory arbiter with locked bursts and lock watchdog
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LOCK_MAX   = 15
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus,
  output logic              lock_abort_o
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  typedef enum logic [1:0] {OPEN, LOCK0, LOCK1} state_t;
  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         idle_q, idle_d;
  logic                  abort_q, abort_d;
  logic                  gnt0, gnt1;
  logic                  rd0, rd1;
  logic                  rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;
  // grant selection, ownership next-state and idle-owner watchdog
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idle_d  = '0;
    abort_d = 1'b0;
    gnt0    = rst & (state_q == LOCK0 ? bus.req0_valid :
                     state_q == OPEN  ? bus.req0_valid & (~bus.req1_valid | last_q) : 1'b0);
    gnt1    = rst & (state_q == LOCK1 ? bus.req1_valid :
                     state_q == OPEN  ? bus.req1_valid & (~bus.req0_valid | ~last_q) : 1'b0);
    if (gnt0 | gnt1) begin
      last_d  = gnt1;
      state_d = gnt1 ? (bus.req1_lock ? LOCK1 : OPEN) : (bus.req0_lock ? LOCK0 : OPEN);
    end else if (state_q != OPEN) begin
      if (idle_q == CW'(LOCK_MAX - 1)) begin
        state_d = OPEN;
        abort_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end
  assign rd0            = gnt0 & ~bus.req0_we;
  assign rd1            = gnt1 & ~bus.req1_we;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mem_addr   = gnt1 ? bus.req1_addr : bus.req0_addr;
  assign bus.mem_wdata  = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  assign bus.mem_we     = (gnt0 & bus.req0_we) | (gnt1 & bus.req1_we);
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign lock_abort_o   = abort_q;
  // arbitration state plus read responses captured at the accept edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= OPEN;
      last_q       <= 1'b1;
      idle_q       <= '0;
      abort_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      idle_q       <= idle_d;
      abort_q      <= abort_d;
      rsp0_valid_q <= rd0;
      rsp1_valid_q <= rd1;
      if (rd0) rsp0_rdata_q <= bus.mem_rdata;
      if (rd1) rsp1_rdata_q <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lock_abort;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp0 = '0;
  logic [31:0] exp1 = '0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mem_arr [256];

  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(17)) bus ();

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LOCK_MAX(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .lock_abort_o(lock_abort)
  );

  always #5 clk = ~clk;

  // memory model: word i initialises to 0xA000_0000 | i during reset
  assign bus.mem_rdata = mem_arr[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (!rst) for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hA000_0000 | 32'(i);
    else if (bus.mem_we) mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set0(input logic v, input logic we, input logic lk, input logic [16:0] a,
                      input logic [31:0] d, input logic [31:0] e);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_lock = lk;
    bus.req0_addr = a; bus.req0_wdata = d; exp0 = e;
  endtask

  task automatic set1(input logic v, input logic we, input logic lk, input logic [16:0] a,
                      input logic [31:0] d, input logic [31:0] e);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_lock = lk;
    bus.req1_addr = a; bus.req1_wdata = d; exp1 = e;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // stimulus side: record the expected word of each accepted read
  always @(negedge clk) begin
    if (bus.req0_valid && bus.req0_ready && !bus.req0_we) q0.push_back(exp0);
    if (bus.req1_valid && bus.req1_ready && !bus.req1_we) q1.push_back(exp1);
  end

  // monitor: every presented response must match the oldest outstanding read
  always @(negedge clk) begin
    if (bus.rsp0_valid) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
      else chk("rsp0_rdata", bus.rsp0_rdata, q0.pop_front());
    end
    if (bus.rsp1_valid) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else chk("rsp1_rdata", bus.rsp1_rdata, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    set0(1, 0, 0, 17'h100, 0, 32'hA000_0040);
    set1(1, 0, 0, 17'h200, 0, 32'hA000_0080);
    step;
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    chk("rst_ready1", 32'(bus.req1_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 0);
    chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 0);
    chk("rst_abort", 32'(lock_abort), 0);
    step;
    chk("rst2_ready0", 32'(bus.req0_ready), 0);
    chk("rst2_ready1", 32'(bus.req1_ready), 0);
    chk("rst2_rsp0_rdata", bus.rsp0_rdata, 0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
      chk("rr_ready1", 32'(bus.req1_ready), 32'(i % 2 == 1));
      step;
    end
    set0(0, 0, 0, 0, 0, 0);
    set1(1, 1, 0, 17'h40, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("wr_ready1", 32'(bus.req1_ready), 1);
    chk("wr_mem_we", 32'(bus.mem_we), 1);
    step;
    set1(0, 0, 0, 0, 0, 0);
    set0(1, 0, 0, 17'h40, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_ready0", 32'(bus.req0_ready), 1);
    chk("rd_mem_we", 32'(bus.mem_we), 0);
    step;
    set0(1, 0, 0, 17'h100, 0, 32'hA000_0040);
    for (int k = 0; k < 4; k++) begin
      set1(1, 1, k < 3, 17'(32'h80 + 4 * k), 32'h1000 + 32'(k), 0);
      @(negedge clk);
      chk("lock_ready1", 32'(bus.req1_ready), 1);
      chk("lock_ready0", 32'(bus.req0_ready), 0);
      step;
    end
    set1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("unlock_ready0", 32'(bus.req0_ready), 1);
    step;
    set0(1, 0, 0, 17'h8C, 0, 32'h0000_1003);
    @(negedge clk);
    chk("burst_rd_ready0", 32'(bus.req0_ready), 1);
    step;
    set0(1, 1, 1, 17'h20, 32'h55, 0);
    @(negedge clk);
    chk("wd_lock_ready0", 32'(bus.req0_ready), 1);
    step;
    set0(0, 0, 0, 0, 0, 0);
    set1(1, 0, 0, 17'h200, 0, 32'hA000_0080);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wd_idle_ready1", 32'(bus.req1_ready), 0);
      chk("wd_idle_abort", 32'(lock_abort), 0);
      step;
    end
    @(negedge clk);
    chk("wd_abort", 32'(lock_abort), 1);
    chk("wd_after_ready1", 32'(bus.req1_ready), 1);
    step;
    set1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wd_abort_pulse", 32'(lock_abort), 0);
    step;
    set0(1, 1, 1, 17'h24, 32'h66, 0);
    @(negedge clk);
    chk("wd2_lock_ready0", 32'(bus.req0_ready), 1);
    step;
    set0(0, 0, 0, 0, 0, 0);
    set1(1, 0, 0, 17'h200, 0, 32'hA000_0080);
    step;
    step;
    set0(1, 1, 0, 17'h28, 32'h77, 0);
    @(negedge clk);
    chk("wd2_owner_ready0", 32'(bus.req0_ready), 1);
    chk("wd2_other_ready1", 32'(bus.req1_ready), 0);
    chk("wd2_no_abort", 32'(lock_abort), 0);
    step;
    set0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wd2_no_abort_late", 32'(lock_abort), 0);
    chk("wd2_open_ready1", 32'(bus.req1_ready), 1);
    step;
    set1(1, 0, 1, 17'h200, 0, 32'hA000_0080);
    @(negedge clk);
    chk("mr_ready1", 32'(bus.req1_ready), 1);
    step;
    rst = 1'b0;
    set1(0, 0, 0, 0, 0, 0);
    set0(1, 0, 0, 17'h100, 0, 32'hA000_0040);
    @(negedge clk);
    chk("mr_rst_ready0", 32'(bus.req0_ready), 0);
    step;
    chk("mr_rsp1_dropped", 32'(bus.rsp1_valid), 0);
    chk("mr_rsp0_dropped", 32'(bus.rsp0_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_open_ready0", 32'(bus.req0_ready), 1);
    step;
    set0(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
